// File: rtl/conv_pkg.sv
// Shared encodings for the CONV result reader: bank selects, bank depths and FSM states.
package conv_pkg;

  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2   = 3'd5;

  localparam int unsigned DEPTH_L0 = 4096;
  localparam int unsigned DEPTH_L1 = 1024;
  localparam int unsigned DEPTH_L2 = 2048;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    RD,
    DRAIN,
    DONE
  } state_t;

  // Unused csel codes report depth 1 so their last address is 0.
  function automatic int unsigned bank_depth(input logic [2:0] sel);
    case (sel)
      CSEL_L0K0, CSEL_L0K1: return DEPTH_L0;
      CSEL_L1K0, CSEL_L1K1: return DEPTH_L1;
      CSEL_L2:              return DEPTH_L2;
      default:              return 1;
    endcase
  endfunction

endpackage

// File: rtl/conv_rd_fifo.sv
// Small synchronous skid FIFO holding {data, csel, addr} entries for the result stream.
module conv_rd_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is cleared on reset so the stream payload reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/conv_result_reader.sv
// Dumps the selected CONV result banks over the local read bus into a tagged valid/ready stream.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        sel_mask,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [2:0]        csel,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_sel,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam int ENT_W = DATA_W + 3 + ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [4:0]        pending;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] bank_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic              fifo_empty;
  logic              pop;
  logic              can_issue;
  logic              pick_valid;
  logic [2:0]        pick_sel;
  logic [4:0]        pick_bit;
  logic [ENT_W-1:0]  head;

  // Stream handshake: a word moves when out_valid & out_ready; while out_valid=1 and
  // out_ready=0 the head entry is held, so the payload cannot change until it is taken.
  assign pop        = out_valid & out_ready;
  assign count_next = fifo_count + CNT_W'(crd) - CNT_W'(pop);
  assign can_issue  = (count_next < CNT_W'(FIFO_DEPTH));
  assign bank_last  = ADDR_W'(bank_depth(csel) - 1);

  always_comb begin
    pick_valid = |pending;
    pick_sel   = '0;
    pick_bit   = '0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) begin
        pick_sel = 3'(i + 1);
        pick_bit = 5'(1 << i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= '0;
      addr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      csel     <= '0;
      caddr_rd <= '0;
    end else begin
      done <= 1'b0;
      crd  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pending <= sel_mask;
            busy    <= 1'b1;
            state   <= SEL;
          end
        end
        SEL: begin
          if (pick_valid) begin
            csel    <= pick_sel;
            pending <= pending & ~pick_bit;
            addr    <= '0;
            state   <= RD;
          end else begin
            state <= DRAIN;
          end
        end
        RD: begin
          if (can_issue) begin
            crd      <= 1'b1;
            caddr_rd <= addr;
            addr     <= addr + 1'b1;
            if (addr == bank_last) state <= SEL;
          end
        end
        DRAIN: begin
          if (count_next == '0 && !crd) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // csel/caddr_rd still carry the issued read's tag when its data lands one cycle later.
  conv_rd_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (crd),
    .push_data ({cdata_rd, csel, caddr_rd}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head[ENT_W-1 -: DATA_W];
  assign out_sel   = head[ADDR_W +: 3];
  assign out_addr  = head[ADDR_W-1:0];
  assign out_last  = out_valid && (out_addr == ADDR_W'(bank_depth(out_sel) - 1));

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: bank-array responder, queue scoreboard, handshake monitor.
module tb_conv_result_reader;

  localparam int DATA_W     = 20;
  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 2;
  localparam int EW         = 1 + 3 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        sel_mask = '0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] cdata_rd = '0;
  logic              busy, done, crd, out_valid, out_last;
  logic [2:0]        csel, out_sel;
  logic [ADDR_W-1:0] caddr_rd, out_addr;
  logic [DATA_W-1:0] out_data;

  conv_result_reader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sel_mask  (sel_mask),
    .busy      (busy),
    .done      (done),
    .crd       (crd),
    .csel      (csel),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference memory and scoreboard state ----------------
  logic [DATA_W-1:0] bank_mem [1:5][0:4095];
  logic [EW-1:0]     exp_q [$];

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int words_seen = 0;
  int last_count = 0;
  int crd_count = 0;
  int valid_count = 0;
  int occ = 0;
  bit prev_crd = 0;
  bit prev_pop = 0;
  bit held = 0;
  bit rand_ready = 0;
  logic [EW-1:0] held_payload = '0;

  function automatic int depth_of(input int b);
    case (b)
      1, 2:    return 4096;
      3, 4:    return 1024;
      default: return 2048;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Memory responder: data for the address strobed this cycle is valid at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (crd) cdata_rd = bank_mem[csel][caddr_rd];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic load_expected(input logic [4:0] mask);
    for (int b = 1; b <= 5; b++) begin
      if (mask[b-1]) begin
        for (int a = 0; a < depth_of(b); a++) begin
          exp_q.push_back({(a == depth_of(b) - 1), 3'(b), ADDR_W'(a), bank_mem[b][a]});
        end
      end
    end
  endtask

  task automatic pulse_start(input logic [4:0] mask, output int sc);
    @(posedge clk);
    #1;
    start    = 1'b1;
    sel_mask = mask;
    sc       = cyc;
    @(posedge clk);
    #1;
    start    = 1'b0;
    sel_mask = 5'($urandom);
  endtask

  task automatic wait_done(input int base, input int budget, output int dend, output bit ok);
    int n = 0;
    while (done_count == base && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok   = (done_count != base);
    dend = cyc;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_crd"}, crd, 0);
    check({name, "_csel"}, csel, 0);
    check({name, "_caddr"}, caddr_rd, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_payload"}, {out_last, out_sel, out_addr, out_data}, 0);
  endtask

  task automatic run_dump(input logic [4:0] mask, input string name, input int exp_lat,
                          input int restart_at);
    int sc, dend, dc, wc, lc, nwords, nlast;
    bit ok;
    dc = done_count;
    wc = words_seen;
    lc = last_count;
    nwords = 0;
    nlast = 0;
    for (int b = 1; b <= 5; b++) begin
      if (mask[b-1]) begin
        nwords += depth_of(b);
        nlast++;
      end
    end
    load_expected(mask);
    pulse_start(mask, sc);
    if (restart_at > 0) begin
      repeat (restart_at) @(posedge clk);
      #1;
      start    = 1'b1;
      sel_mask = 5'b11111;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(dc, 20000, dend, ok);
    check({name, "_done_seen"}, ok, 1);
    if (ok && exp_lat >= 0) check({name, "_latency"}, dend - sc, exp_lat);
    repeat (2) @(negedge clk);
    #1;
    check({name, "_words"}, words_seen - wc, nwords);
    check({name, "_last_pulses"}, last_count - lc, nlast);
    check({name, "_done_pulses"}, done_count - dc, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_after"}, busy, 0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] payload;
    logic [EW-1:0] want;
    forever begin
      @(negedge clk);
      if (!reset) begin
        occ      = 0;
        prev_crd = 0;
        prev_pop = 0;
        held     = 0;
      end else begin
        occ = occ + int'(prev_crd) - int'(prev_pop);
        if (crd) begin
          crd_count++;
          check("crd_room", (occ < FIFO_DEPTH), 1);
        end
        payload = {out_last, out_sel, out_addr, out_data};
        if (held) check("stall_stable", {out_valid, payload}, {1'b1, held_payload});
        if (done) done_count++;
        if (out_valid) valid_count++;
        if (out_valid && out_ready) begin
          words_seen++;
          if (out_last) last_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", payload, 0);
          end else begin
            want = exp_q.pop_front();
            check("stream_word", payload, want);
          end
        end
        prev_crd     = crd;
        prev_pop     = out_valid && out_ready;
        held         = out_valid && !out_ready;
        held_payload = payload;
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int dc, cc, vc, wc, sc, n;
    for (int b = 1; b <= 5; b++)
      for (int a = 0; a < 4096; a++) bank_mem[b][a] = DATA_W'($urandom);

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    rand_ready = 0;
    run_dump(5'b00001, "l0k0", 4096 + 1 + 3, 0);

    run_dump(5'b10100, "l1k0_l2", 1024 + 2048 + 2 + 3, 0);

    rand_ready = 1;
    run_dump(5'b00100, "l1k0_stall", -1, 0);
    rand_ready = 0;

    cc = crd_count;
    vc = valid_count;
    run_dump(5'b00000, "empty_mask", 3, 0);
    check("empty_mask_no_crd", crd_count - cc, 0);
    check("empty_mask_no_valid", valid_count - vc, 0);

    run_dump(5'b00010, "restart_ignored", 4096 + 1 + 3, 10);

    // Abort a dump part way through bank 001.
    dc = done_count;
    wc = words_seen;
    load_expected(5'b00001);
    pulse_start(5'b00001, sc);
    n = 0;
    while ((words_seen - wc) < 500 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reached_word_500", words_seen - wc, 500);
    reset = 1'b0;
    #1;
    check_zero_outputs("abort");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_crd", crd, 0);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", done_count - dc, 0);
    run_dump(5'b00001, "after_abort", 4096 + 1 + 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
